// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB digit first.
// A start/done handshake wraps the adder; the DONE cycle also accepts a new start.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg, ovf_reg;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] dsum_top, res_shift;
    logic             last, accept;

    // One full adder per digit bit, each made of two half-adder stages.
    assign chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            logic p, g1, g2;
            assign p             = a_reg[gi] ^ b_reg[gi];
            assign g1            = a_reg[gi] & b_reg[gi];
            assign dsum[gi]      = p ^ chain[gi];
            assign g2            = p & chain[gi];
            assign chain[gi + 1] = g1 | g2;
        end
    endgenerate

    assign dsum_top  = WIDTH'(dsum) << (WIDTH - DIGIT);
    assign res_shift = (res_reg >> DIGIT) | dsum_top;
    assign last      = (count_reg == CW'(N - 1));
    assign accept    = start && (state_reg != ADD);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last) state_next = DONE;
            DONE:    state_next = start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                res_reg   <= '0;
                count_reg <= '0;
            end else if (state_reg == ADD) begin
                a_reg     <= a_reg >> DIGIT;
                b_reg     <= b_reg >> DIGIT;
                res_reg   <= res_shift;
                carry_reg <= chain[DIGIT];
                count_reg <= last ? '0 : count_reg + CW'(1);
                // Visible outputs only change once the whole word is assembled.
                if (last) begin
                    sum_reg  <= res_shift;
                    cout_reg <= chain[DIGIT];
                    ovf_reg  <= chain[DIGIT] ^ chain[DIGIT-1];
                end
            end
        end
    end

    assign busy = (state_reg == ADD);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three configurations (8/1, 2/1, 8/4) checked
// against an arithmetic reference model, a vector table and handshake/reset sequences.
module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a, b;
    logic       cin;
    logic       st1, st2, st3;

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;
    logic       busy3, done3, cout3, ovf3;
    logic [7:0] sum3;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(st1), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );
    serial_adder #(.WIDTH(2), .DIGIT(1)) u_w2d1 (
        .clk(clk), .rst(rst), .start(st2), .a(a[1:0]), .b(b[1:0]), .cin(cin),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(st3), .a(a), .b(b), .cin(cin),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );

    int         sel = 1;
    logic       busy_m, done_m, cout_m, ovf_m;
    logic [7:0] sum_m;

    always_comb begin
        busy_m = 1'b0;
        done_m = 1'b0;
        cout_m = 1'b0;
        ovf_m  = 1'b0;
        sum_m  = 8'h00;
        case (sel)
            1: begin busy_m = busy1; done_m = done1; cout_m = cout1; ovf_m = ovf1; sum_m = sum1; end
            2: begin busy_m = busy2; done_m = done2; cout_m = cout2; ovf_m = ovf2; sum_m = {6'b0, sum2}; end
            3: begin busy_m = busy3; done_m = done3; cout_m = cout3; ovf_m = ovf3; sum_m = sum3; end
            default: ;
        endcase
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 2) ? 2 : 8;
    endfunction

    function automatic int cycles_of(input int s);
        return (s == 1) ? 8 : 2;
    endfunction

    typedef struct {
        int sum;
        int cout;
        int ovf;
    } res_t;

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic res_t model(input int w, input int av, input int bv, input int cv);
        res_t r;
        int   mask, t, am, bm, sm;
        mask  = (1 << w) - 1;
        t     = (av & mask) + (bv & mask) + cv;
        r.sum = t & mask;
        r.cout = (t >> w) & 1;
        am    = ((av & mask) >> (w - 1)) & 1;
        bm    = ((bv & mask) >> (w - 1)) & 1;
        sm    = (r.sum >> (w - 1)) & 1;
        r.ovf = ((am == bm) && (sm != am)) ? 1 : 0;
        return r;
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            1: st1 = v;
            2: st2 = v;
            default: st3 = v;
        endcase
    endtask

    // Starts an add, scrambles operands after acceptance, returns at the done cycle.
    task automatic run_add(input int s, input int av, input int bv, input int cv,
                           output int gs, output int gc, output int go, output int lat);
        sel = s;
        a   = av[7:0];
        b   = bv[7:0];
        cin = cv[0];
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        lat = 1;
        while (!done_m && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        gs = int'(sum_m);
        gc = int'(cout_m);
        go = int'(ovf_m);
    endtask

    task automatic add_and_check(input string tag, input int s, input int av, input int bv, input int cv);
        int   gs, gc, go, lat;
        res_t m;
        run_add(s, av, bv, cv, gs, gc, go, lat);
        m = model(width_of(s), av, bv, cv);
        $display("[TB] %s cfg%0d %0h+%0h+%0d -> sum=%0h cout=%0d ovf=%0d lat=%0d",
                 tag, s, av, bv, cv, gs, gc, go, lat);
        check({tag, "_sum"}, gs, m.sum);
        check({tag, "_cout"}, gc, m.cout);
        check({tag, "_ovf"}, go, m.ovf);
        check({tag, "_lat"}, lat, cycles_of(s) + 1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, int'(done_m), 0);
        check({tag, "_hold"}, int'(sum_m), m.sum);
    endtask

    typedef struct {
        int s;
        int av;
        int bv;
        int cv;
        int es;
        int ec;
        int eo;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   gs, gc, go, lat, ndone, first_sum;

        rst = 1'b1; st1 = 1'b1; st2 = 1'b1; st3 = 1'b1;
        a = 8'hFF; b = 8'h01; cin = 1'b1;

        // Reset held two cycles with start high: nothing may begin.
        repeat (2) @(posedge clk);
        #1;
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #0;
            check("rst_busy", int'(busy_m), 0);
            check("rst_done", int'(done_m), 0);
            check("rst_sum", int'(sum_m), 0);
            check("rst_cout", int'(cout_m), 0);
            check("rst_ovf", int'(ovf_m), 0);
        end
        rst = 1'b0; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
        @(posedge clk); #1;
        sel = 1;
        #0;
        check("post_rst_idle", int'(busy_m), 0);

        // Fixed vectors, expected values worked out by hand.
        vecs[0] = '{1, 'hFF, 'h01, 0, 'h00, 1, 0};
        vecs[1] = '{1, 'h7F, 'h01, 0, 'h80, 0, 1};
        vecs[2] = '{3, 'h3C, 'hC5, 1, 'h02, 1, 0};
        vecs[3] = '{2, 3, 3, 1, 3, 1, 0};
        vecs[4] = '{2, 1, 1, 0, 2, 0, 1};
        vecs[5] = '{3, 'h80, 'h80, 0, 'h00, 1, 1};
        for (int i = 0; i < 6; i++) begin
            run_add(vecs[i].s, vecs[i].av, vecs[i].bv, vecs[i].cv, gs, gc, go, lat);
            $display("[TB] vec%0d cfg%0d sum=%0h cout=%0d ovf=%0d lat=%0d", i, vecs[i].s, gs, gc, go, lat);
            check("vec_sum", gs, vecs[i].es);
            check("vec_cout", gc, vecs[i].ec);
            check("vec_ovf", go, vecs[i].eo);
            check("vec_lat", lat, cycles_of(vecs[i].s) + 1);
            @(posedge clk); #1;
        end

        // Exhaustive 2-bit configuration.
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    add_and_check("exh", 2, x, y, c);

        // Random operands on both 8-bit configurations.
        for (int i = 0; i < 20; i++) begin
            add_and_check("rnd", 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 1)));
            add_and_check("rnd", 3, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 1)));
        end

        // start pulsed mid-add is ignored: exactly one done with the first result.
        sel = 1;
        a = 8'h12; b = 8'h34; cin = 1'b0; st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0;
        ndone = 0;
        first_sum = -1;
        for (int i = 0; i < 20; i++) begin
            if (done_m) begin
                ndone++;
                if (first_sum < 0) first_sum = int'(sum_m);
            end
            @(posedge clk); #1;
        end
        $display("[TB] ignore_start dones=%0d sum=%0h", ndone, first_sum);
        check("ignore_ndone", ndone, 1);
        check("ignore_sum", first_sum, 'h46);

        // Back-to-back: start during the DONE cycle is accepted.
        run_add(1, 'h10, 'h20, 0, gs, gc, go, lat);
        check("b2b_first_sum", gs, 'h30);
        a = 8'h55; b = 8'h0A; cin = 1'b1; st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0;
        check("b2b_busy", int'(busy_m), 1);
        lat = 1;
        while (!done_m && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("[TB] back_to_back sum=%0h lat=%0d", sum_m, lat);
        check("b2b_lat", lat, 9);
        check("b2b_sum", int'(sum_m), 'h60);
        @(posedge clk); #1;

        // Reset in the middle of an add aborts it.
        a = 8'hAA; b = 8'h55; cin = 1'b1; st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy_before", int'(busy_m), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy_m), 0);
        check("midrst_sum", int'(sum_m), 0);
        check("midrst_cout", int'(cout_m), 0);
        check("midrst_ovf", int'(ovf_m), 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_m) ndone++;
            @(posedge clk); #1;
        end
        $display("[TB] mid_reset dones=%0d", ndone);
        check("midrst_no_done", ndone, 0);
        add_and_check("after_rst", 1, 'hAA, 'h55, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
